// File: rtl/macro_reduction_seq_and.sv
// macro_reduction_seq_and
// Multi-pass AND-reduction sequencer. One request of INPUT_COUNT operands is
// latched, then reduced CHUNK_COUNT operands per cycle through a small
// combinational AND tree into an accumulator. The result is held in DONE
// until the consumer takes it.
// Optional build macro: MACRO_REDUCTION_SEQ_EARLY_EXIT_EN -- finish as soon as
// the running AND reaches zero, reporting the passes actually used.
module macro_reduction_seq_and #(
    parameter int INPUT_WIDTH = 8,
    parameter int INPUT_COUNT = 16,
    parameter int CHUNK_COUNT = 4,
    localparam int PASSES = (INPUT_COUNT + ((CHUNK_COUNT < 1) ? 1 : CHUNK_COUNT) - 1)
                            / ((CHUNK_COUNT < 1) ? 1 : CHUNK_COUNT),
    localparam int PASS_W = $clog2(PASSES + 1)
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic [INPUT_WIDTH*INPUT_COUNT-1:0] i_d,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [INPUT_WIDTH-1:0]             o_q,
    output logic [PASS_W-1:0]                  o_passes,
    output logic                               o_busy
);

    localparam int CNT_W = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int LANES = PASSES * CHUNK_COUNT;
    localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(PASSES - 1);
    localparam logic [PASS_W-1:0] PASSES_VAL = PASS_W'(PASSES);

    if (INPUT_COUNT < 1 || CHUNK_COUNT < 1) begin : g_bad_params
        $error("macro_reduction_seq_and: INPUT_COUNT and CHUNK_COUNT must both be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                             state_reg;
    logic [INPUT_WIDTH*INPUT_COUNT-1:0] operand_reg;
    logic [INPUT_WIDTH-1:0]             acc_reg;
    logic [CNT_W-1:0]                   cnt_reg;

    // Operand register viewed as [pass][lane]; lanes past the last real
    // operand read as all-ones so they never clear result bits.
    logic [INPUT_WIDTH-1:0] padded [PASSES][CHUNK_COUNT];
    logic [INPUT_WIDTH-1:0] tree_and;
    logic [INPUT_WIDTH-1:0] acc_next;
    logic                   exit_now;
    logic [PASS_W-1:0]      passes_now;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        if (gi < INPUT_COUNT) begin : g_real
            assign padded[gi / CHUNK_COUNT][gi % CHUNK_COUNT] =
                operand_reg[gi*INPUT_WIDTH +: INPUT_WIDTH];
        end else begin : g_pad
            assign padded[gi / CHUNK_COUNT][gi % CHUNK_COUNT] = '1;
        end
    end

    // Chunk-wide AND tree over the chunk selected by the pass counter.
    always_comb begin
        tree_and = '1;
        for (int l = 0; l < CHUNK_COUNT; l++) begin
            tree_and = tree_and & padded[cnt_reg][l];
        end
        acc_next = acc_reg & tree_and;
    end

    // Decide whether this pass is the final one and how many passes it took.
`ifdef MACRO_REDUCTION_SEQ_EARLY_EXIT_EN
    always_comb begin
        exit_now   = (cnt_reg == LAST_CNT) || (acc_next == '0);
        passes_now = PASS_W'(cnt_reg) + PASS_W'(1);
    end
`else
    always_comb begin
        exit_now   = (cnt_reg == LAST_CNT);
        passes_now = PASSES_VAL;
    end
`endif

    // Control FSM with registered handshake/status outputs and datapath state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= ST_IDLE;
            operand_reg <= '0;
            acc_reg     <= '0;
            cnt_reg     <= '0;
            o_ready     <= 1'b1;
            o_valid     <= 1'b0;
            o_busy      <= 1'b0;
            o_q         <= '0;
            o_passes    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_valid) begin
                        operand_reg <= i_d;
                        acc_reg     <= '1;
                        cnt_reg     <= '0;
                        o_ready     <= 1'b0;
                        o_busy      <= 1'b1;
                        state_reg   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    acc_reg <= acc_next;
                    if (exit_now) begin
                        o_q       <= acc_next;
                        o_passes  <= passes_now;
                        o_valid   <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        o_valid   <= 1'b0;
                        o_ready   <= 1'b1;
                        o_busy    <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    o_valid   <= 1'b0;
                    o_ready   <= 1'b1;
                    o_busy    <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_macro_reduction_seq_and.sv
// Directed bench for macro_reduction_seq_and: a 16-operand / 4-lane instance
// (four passes) and a 10-operand / 4-lane instance (three passes, padded).
module tb_macro_reduction_seq_and;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // Instance A: W=8, N=16, C=4 -> PASSES=4
    logic         a_i_valid = 1'b0;
    logic         a_o_ready;
    logic [127:0] a_i_d = '0;
    logic         a_o_valid;
    logic         a_i_ready = 1'b0;
    logic [7:0]   a_o_q;
    logic [2:0]   a_o_passes;
    logic         a_o_busy;

    // Instance B: W=8, N=10, C=4 -> PASSES=3
    logic         b_i_valid = 1'b0;
    logic         b_o_ready;
    logic [79:0]  b_i_d = '0;
    logic         b_o_valid;
    logic         b_i_ready = 1'b0;
    logic [7:0]   b_o_q;
    logic [1:0]   b_o_passes;
    logic         b_o_busy;

    macro_reduction_seq_and #(.INPUT_WIDTH(8), .INPUT_COUNT(16), .CHUNK_COUNT(4)) dut_a (
        .clk(clk), .resetn(resetn),
        .i_valid(a_i_valid), .o_ready(a_o_ready), .i_d(a_i_d),
        .o_valid(a_o_valid), .i_ready(a_i_ready), .o_q(a_o_q),
        .o_passes(a_o_passes), .o_busy(a_o_busy)
    );

    macro_reduction_seq_and #(.INPUT_WIDTH(8), .INPUT_COUNT(10), .CHUNK_COUNT(4)) dut_b (
        .clk(clk), .resetn(resetn),
        .i_valid(b_i_valid), .o_ready(b_o_ready), .i_d(b_i_d),
        .o_valid(b_o_valid), .i_ready(b_i_ready), .o_q(b_o_q),
        .o_passes(b_o_passes), .o_busy(b_o_busy)
    );

    int tests = 0;
    int fails = 0;
    bit cur_b = 1'b0;

    logic       obs_valid, obs_ready, obs_busy;
    logic [7:0] obs_q;
    logic [2:0] obs_passes;
    assign obs_valid  = cur_b ? b_o_valid : a_o_valid;
    assign obs_ready  = cur_b ? b_o_ready : a_o_ready;
    assign obs_busy   = cur_b ? b_o_busy  : a_o_busy;
    assign obs_q      = cur_b ? b_o_q     : a_o_q;
    assign obs_passes = cur_b ? {1'b0, b_o_passes} : a_o_passes;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [127:0] fill(input logic [7:0] v);
        return {16{v}};
    endfunction

    task automatic set_valid(input logic v);
        if (cur_b) b_i_valid = v; else a_i_valid = v;
    endtask

    task automatic set_ready(input logic v);
        if (cur_b) b_i_ready = v; else a_i_ready = v;
    endtask

    task automatic set_data(input logic [127:0] d);
        if (cur_b) b_i_d = d[79:0]; else a_i_d = d;
    endtask

    // Issue one request and complete it; called #1 after a rising edge.
    task automatic run_req(input string tag, input logic [127:0] d,
                           input logic [7:0] exp_q, input int exp_passes, input int exp_lat);
        int lat;
        chk({tag, "_ready_before"}, 32'(obs_ready), 32'd1);
        set_data(d);
        set_valid(1'b1);
        set_ready(1'b0);
        @(posedge clk); #1;
        set_valid(1'b0);
        chk({tag, "_busy_after_accept"}, 32'(obs_busy), 32'd1);
        chk({tag, "_ready_after_accept"}, 32'(obs_ready), 32'd0);
        lat = 0;
        while (!obs_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_q"}, 32'(obs_q), 32'(exp_q));
        chk({tag, "_passes"}, 32'(obs_passes), 32'(exp_passes));
        chk({tag, "_ready_done"}, 32'(obs_ready), 32'd0);
        set_ready(1'b1);
        @(posedge clk); #1;
        set_ready(1'b0);
        chk({tag, "_valid_after_hs"}, 32'(obs_valid), 32'd0);
        chk({tag, "_ready_after_hs"}, 32'(obs_ready), 32'd1);
        chk({tag, "_busy_after_hs"}, 32'(obs_busy), 32'd0);
        chk({tag, "_q_kept"}, 32'(obs_q), 32'(exp_q));
        $display("[TB] %s: q=%02h passes=%0d latency=%0d", tag, obs_q, obs_passes, lat);
    endtask

    logic [127:0] vec;
    int           wait_cnt;

    initial begin
        // Reset state (both instances)
        @(posedge clk); #1;
        cur_b = 1'b0;
        chk("rst_a_valid", 32'(a_o_valid), 32'd0);
        chk("rst_a_ready", 32'(a_o_ready), 32'd1);
        chk("rst_a_busy", 32'(a_o_busy), 32'd0);
        chk("rst_a_q", 32'(a_o_q), 32'd0);
        chk("rst_a_passes", 32'(a_o_passes), 32'd0);
        chk("rst_b_ready", 32'(b_o_ready), 32'd1);
        resetn = 1'b1;
        @(posedge clk); #1;

        // 1. all 0xFF
        run_req("all_ff", fill(8'hFF), 8'hFF, 4, 4);

        // 2. operand 13 = 0x0F
        vec = fill(8'hFF);
        vec[13*8 +: 8] = 8'h0F;
        run_req("op13_0f", vec, 8'h0F, 4, 4);

        // 2b. operand 2 = 0x3C, operand 9 = 0xF0 (back-to-back issue)
        vec = fill(8'hFF);
        vec[2*8 +: 8] = 8'h3C;
        vec[9*8 +: 8] = 8'hF0;
        run_req("op2_op9", vec, 8'h30, 4, 4);

        // 3. N=10 instance, all 0xF0, padded lanes must not clear bits
        cur_b = 1'b1;
        run_req("n10_f0", fill(8'hF0), 8'hF0, 3, 3);
        vec = fill(8'hFF);
        vec[9*8 +: 8] = 8'h81;
        run_req("n10_last_op", vec, 8'h81, 3, 3);
        cur_b = 1'b0;

        // 4. backpressure in DONE with new request pulsed
        a_i_d = fill(8'hFF);
        a_i_valid = 1'b1;
        @(posedge clk); #1;
        a_i_valid = 1'b0;
        wait_cnt = 0;
        while (!a_o_valid && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        chk("bp_latency", 32'(wait_cnt), 32'd4);
        a_i_d = fill(8'h00);
        a_i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_valid_held", 32'(a_o_valid), 32'd1);
            chk("bp_q_held", 32'(a_o_q), 32'hFF);
            chk("bp_passes_held", 32'(a_o_passes), 32'd4);
            chk("bp_ready_low", 32'(a_o_ready), 32'd0);
        end
        a_i_valid = 1'b0;
        a_i_ready = 1'b1;
        @(posedge clk); #1;
        a_i_ready = 1'b0;
        chk("bp_valid_after_hs", 32'(a_o_valid), 32'd0);
        chk("bp_ready_after_hs", 32'(a_o_ready), 32'd1);
        chk("bp_busy_after_hs", 32'(a_o_busy), 32'd0);
        chk("bp_q_not_relatched", 32'(a_o_q), 32'hFF);
        $display("[TB] backpressure: q=%02h held 5 cycles", a_o_q);
        vec = fill(8'hFF);
        vec[5*8 +: 8] = 8'hA5;
        run_req("after_bp", vec, 8'hA5, 4, 4);

        // 5. async reset during pass 2
        a_i_d = fill(8'hFF);
        a_i_valid = 1'b1;
        @(posedge clk); #1;
        a_i_valid = 1'b0;
        @(posedge clk); #1;
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(a_o_valid), 32'd0);
        chk("arst_busy", 32'(a_o_busy), 32'd0);
        chk("arst_q", 32'(a_o_q), 32'd0);
        chk("arst_passes", 32'(a_o_passes), 32'd0);
        chk("arst_ready", 32'(a_o_ready), 32'd1);
        $display("[TB] async reset mid-busy: q=%02h busy=%0b", a_o_q, a_o_busy);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        chk("arst_ready_after", 32'(a_o_ready), 32'd1);
        vec = fill(8'hFF);
        vec[7*8 +: 8] = 8'h3C;
        run_req("after_arst", vec, 8'h3C, 4, 4);

        // 6. operand 1 = 0x00
        vec = fill(8'hFF);
        vec[1*8 +: 8] = 8'h00;
`ifdef MACRO_REDUCTION_SEQ_EARLY_EXIT_EN
        run_req("op1_zero", vec, 8'h00, 1, 1);
`else
        run_req("op1_zero", vec, 8'h00, 4, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
